key_debouncer: RTL and testbench

- Conditions one raw DE1-SoC pushbutton (KEY, active-low, bouncy, asynchronous) into clean, synchronous control signals.
- Sits directly upstream of the LED blinker/FSM blocks on CLOCK_50 and feeds them:
  - a debounced level;
  - single-cycle press/release strobes they can use to start, stop or change state.

---
 rtl/key_debouncer.sv | 176 +++++++++++++++++
 tb/tb_key_debouncer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/key_debouncer.sv
// key_debouncer: conditions one raw active-low pushbutton into a debounced level plus
// single-cycle press/release strobes, all synchronous to CLOCK_50.
// Optional feature: define AUTO_REPEAT_EN to add press_pulse auto-repeat while held.
module key_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic CLOCK_50,
    input  logic RESET_N,
    input  logic KEY_N,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse
);

`ifdef AUTO_REPEAT_EN
    localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                    : REPEAT_PERIOD;
    localparam int unsigned CntMax = (RptMax > DEBOUNCE_CYCLES) ? RptMax : DEBOUNCE_CYCLES;
`else
    localparam int unsigned CntMax = DEBOUNCE_CYCLES;
`endif
    localparam int unsigned CntW = $clog2(CntMax) + 1;

    localparam logic [CntW-1:0] DebLast = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    // Reject parameter sets the counters cannot honour.
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("key_debouncer: illegal parameter value");
    end

    typedef enum logic [1:0] {
        StReleased,
        StPressCheck,
        StPressed,
        StReleaseCheck
    } state_e;

    state_e          state_q, state_d;
    logic            sync1_q, ks_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            release_q, release_d;

`ifdef AUTO_REPEAT_EN
    localparam logic [CntW-1:0] RptDelayLast  = CntW'(REPEAT_DELAY - 1);
    localparam logic [CntW-1:0] RptPeriodLast = CntW'(REPEAT_PERIOD - 1);

    logic [CntW-1:0] rpt_q, rpt_d;
    // armed_q set once the initial delay has elapsed; later strobes use the period.
    logic            armed_q, armed_d;
`endif

    // Next-state, counter and registered-output decode driven only by the synchronized key.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
`ifdef AUTO_REPEAT_EN
        rpt_d     = rpt_q;
        armed_d   = armed_q;
`endif
        unique case (state_q)
            StReleased: begin
                level_d = 1'b0;
                if (!ks_q) begin
                    state_d = StPressCheck;
                    cnt_d   = '0;
                end
            end
            StPressCheck: begin
                if (ks_q) begin
                    // Bounce: back to idle without a strobe.
                    state_d = StReleased;
                    cnt_d   = '0;
                end else if (cnt_q == DebLast) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
`ifdef AUTO_REPEAT_EN
                    rpt_d   = '0;
                    armed_d = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StPressed: begin
                level_d = 1'b1;
                if (ks_q) begin
                    // Repeat counter holds its value while the release is being qualified.
                    state_d = StReleaseCheck;
                    cnt_d   = '0;
                end else begin
`ifdef AUTO_REPEAT_EN
                    if (!armed_q) begin
                        if (rpt_q == RptDelayLast) begin
                            press_d = 1'b1;
                            rpt_d   = '0;
                            armed_d = 1'b1;
                        end else begin
                            rpt_d = rpt_q + CntOne;
                        end
                    end else begin
                        if (rpt_q == RptPeriodLast) begin
                            press_d = 1'b1;
                            rpt_d   = '0;
                        end else begin
                            rpt_d = rpt_q + CntOne;
                        end
                    end
`endif
                end
            end
            StReleaseCheck: begin
                // key_level stays high until the release is fully qualified.
                if (!ks_q) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                end else if (cnt_q == DebLast) begin
                    state_d   = StReleased;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: begin
                state_d = StReleased;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    // Synchronizer, FSM state, counters and registered outputs with synchronous reset.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            sync1_q   <= 1'b1;
            ks_q      <= 1'b1;
            state_q   <= StReleased;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rpt_q     <= '0;
            armed_q   <= 1'b0;
`endif
        end else begin
            sync1_q   <= KEY_N;
            ks_q      <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
`ifdef AUTO_REPEAT_EN
            rpt_q     <= rpt_d;
            armed_q   <= armed_d;
`endif
        end
    end

    assign key_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Directed testbench for key_debouncer (DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5).
// In every task, key_n is the value present before edge i, and outputs are sampled 1 time unit
// after edge i as {key_level, press_pulse, release_pulse}.
module tb_key_debouncer;

    logic clk;
    logic rst_n;
    logic key_n;
    logic key_level;
    logic press_pulse;
    logic release_pulse;

    int total;
    int bad;

    key_debouncer #(
        .DEBOUNCE_CYCLES(8),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (5)
    ) dut (
        .CLOCK_50     (clk),
        .RESET_N      (rst_n),
        .KEY_N        (key_n),
        .key_level    (key_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset held 3 cycles with key up, then 50 idle cycles: everything stays low.
    task automatic test_reset();
        logic [2:0] obs;
        for (int i = 1; i <= 53; i++) begin
            rst_n = (i > 3);
            key_n = 1'b1;
            @(posedge clk);
            #1;
            obs = {key_level, press_pulse, release_pulse};
            total++;
            if (obs !== 3'b000) begin
                bad++;
                $display("FAIL reset_idle cycle %0d got %b want %b", i, obs, 3'b000);
            end
        end
    endtask

    // Clean press: strobe exactly at edge 11 (2 sync + 8 debounce + 1).
    task automatic test_press();
        logic [2:0] obs, exp;
        for (int i = 1; i <= 20; i++) begin
            key_n = 1'b0;
            @(posedge clk);
            #1;
            exp = {i >= 11, i == 11, 1'b0};
            obs = {key_level, press_pulse, release_pulse};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL press cycle %0d got %b want %b", i, obs, exp);
            end
        end
    endtask

    // Clean release from the held state: release strobe at edge 11.
    task automatic test_release();
        logic [2:0] obs, exp;
        for (int i = 1; i <= 15; i++) begin
            key_n = 1'b1;
            @(posedge clk);
            #1;
            exp = {i < 11, 1'b0, i == 11};
            obs = {key_level, press_pulse, release_pulse};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL release cycle %0d got %b want %b", i, obs, exp);
            end
        end
    endtask

    // Press, then a 5-cycle release bounce (rejected), then a real release rising before edge 20.
    task automatic test_release_bounce();
        logic [2:0] obs, exp;
        for (int i = 1; i <= 34; i++) begin
            if (i <= 11)      key_n = 1'b0;
            else if (i <= 16) key_n = 1'b1;
            else if (i <= 19) key_n = 1'b0;
            else              key_n = 1'b1;
            @(posedge clk);
            #1;
            exp = {(i >= 11) && (i < 30), i == 11, i == 30};
            obs = {key_level, press_pulse, release_pulse};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL release_bounce cycle %0d got %b want %b", i, obs, exp);
            end
        end
    endtask

    // Long hold: repeats at acceptance+20, +25 .. +50 only when AUTO_REPEAT_EN is defined.
    task automatic test_auto_repeat();
        logic [2:0] obs, exp;
        logic       rep;
        for (int i = 1; i <= 78; i++) begin
            key_n = (i >= 63);
            @(posedge clk);
            #1;
`ifdef AUTO_REPEAT_EN
            rep = (i >= 31) && (i <= 61) && (((i - 31) % 5) == 0);
`else
            rep = 1'b0;
`endif
            exp = {(i >= 11) && (i < 73), (i == 11) || rep, i == 73};
            obs = {key_level, press_pulse, release_pulse};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL auto_repeat cycle %0d got %b want %b", i, obs, exp);
            end
        end
    endtask

    // Key toggling every 3 cycles for 30 cycles, then low from edge 31: one press at edge 41.
    task automatic test_bouncy_press();
        logic [2:0] obs, exp;
        for (int i = 1; i <= 45; i++) begin
            if (i <= 30) key_n = (((i - 1) / 3) % 2) == 1;
            else         key_n = 1'b0;
            @(posedge clk);
            #1;
            exp = {i >= 41, i == 41, 1'b0};
            obs = {key_level, press_pulse, release_pulse};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL bouncy_press cycle %0d got %b want %b", i, obs, exp);
            end
        end
    endtask

    // Reset pulse while held: level drops silently, re-press 10 cycles after reset releases.
    task automatic test_reset_while_pressed();
        logic [2:0] obs, exp;
        for (int i = 1; i <= 15; i++) begin
            key_n = 1'b0;
            rst_n = (i != 2);
            @(posedge clk);
            #1;
            exp = {(i == 1) || (i >= 13), i == 13, 1'b0};
            obs = {key_level, press_pulse, release_pulse};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL reset_while_pressed cycle %0d got %b want %b", i, obs, exp);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        key_n = 1'b1;
        test_reset();
        test_press();
        test_release();
        test_release_bounce();
        test_auto_repeat();
        test_bouncy_press();
        test_reset_while_pressed();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
